// File: rtl/snow64_bfloat16_binop_issuer_pkg.sv
// Shared types and constants for the BFloat16 binary-op issuer.
// Also provides the state-width define used by the StateIssuer enum.
`define MSB_POS__SNOW64_BFLOAT16_ISSUER_STATE 1

package snow64_bfloat16_binop_issuer_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 16;
    localparam int VEC_W     = NUM_LANES * LANE_W;
    localparam logic [LANE_W-1:0] BF16_QNAN = 16'h7fc0;

    typedef enum logic [`MSB_POS__SNOW64_BFLOAT16_ISSUER_STATE:0] {
        StIssIdle,
        StIssSend,
        StIssWait,
        StIssDone
    } StateIssuer;

    // Unit-side command and response bundles shared by add/mul/div units.
    typedef struct packed {
        logic              start;
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
    } PortIn_BinOp;

    typedef struct packed {
        logic              data_valid;
        logic              can_accept_cmd;
        logic [LANE_W-1:0] data;
    } PortOut_Oper;

    // Vector-side bundles for callers that prefer grouped ports.
    typedef struct packed {
        logic                 start;
        logic [VEC_W-1:0]     a;
        logic [VEC_W-1:0]     b;
        logic [NUM_LANES-1:0] lane_mask;
    } PortIn_Issuer;

    typedef struct packed {
        logic             can_accept;
        logic             data_valid;
        logic [VEC_W-1:0] data;
        logic             timeout;
    } PortOut_Issuer;

    function automatic logic [LANE_W-1:0] get_lane(input logic [VEC_W-1:0] v,
                                                   input logic [1:0] idx);
        return v[{idx, 4'b0000} +: LANE_W];
    endfunction

endpackage

// File: rtl/snow64_bfloat16_binop_issuer_lane_picker.sv
// Priority encoder: lowest-index pending lane plus an any-pending flag.
module snow64_bfloat16_lane_picker
    import snow64_bfloat16_binop_issuer_pkg::*;
(
    input  logic [NUM_LANES-1:0] pending_i,
    output logic [1:0]           lane_o,
    output logic                 any_o
);

    always_comb begin
        lane_o = 2'd0;
        any_o  = 1'b0;
        // Scan downward so the lowest set bit is the last to win.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                lane_o = 2'(i);
                any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snow64_bfloat16_binop_issuer.sv
// Issues masked BFloat16 lanes one at a time to a single binary-op unit.
// Optional watchdog: define SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN.
module snow64_bfloat16_binop_issuer
    import snow64_bfloat16_binop_issuer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_start,
    input  logic [VEC_W-1:0]     in_a,
    input  logic [VEC_W-1:0]     in_b,
    input  logic [NUM_LANES-1:0] in_lane_mask,
    output logic                 out_can_accept,
    output logic                 out_data_valid,
    output logic [VEC_W-1:0]     out_data,
    output logic                 out_timeout,
    output PortIn_BinOp          out_to_unit,
    input  PortOut_Oper          in_from_unit,
    output StateIssuer           out_dbg_state
);

    // Unit handshake: a command transfers in a cycle where start=1 and
    // can_accept_cmd=1; a result transfers in any Wait cycle with data_valid=1.
    StateIssuer           state_q;
    logic [VEC_W-1:0]     a_q;
    logic [VEC_W-1:0]     b_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [VEC_W-1:0]     result_q;
    logic                 valid_q;
    logic [1:0]           lane_sel;
    logic                 any_pending;

    snow64_bfloat16_lane_picker u_picker (
        .pending_i (mask_q),
        .lane_o    (lane_sel),
        .any_o     (any_pending)
    );

`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
    localparam logic [4:0] WD_MAX = 5'd31;
    logic [4:0] wd_q;
    logic       timeout_q;
    assign out_timeout = timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIssIdle;
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIssIdle: begin
                    if (in_start) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        mask_q   <= in_lane_mask;
                        result_q <= in_a;
                        state_q  <= StIssSend;
`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                StIssSend: begin
                    if (!any_pending) begin
                        state_q <= StIssDone;
                        valid_q <= 1'b1;
                    end else if (in_from_unit.can_accept_cmd) begin
                        state_q <= StIssWait;
`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
                        wd_q <= '0;
`endif
                    end
                end
                StIssWait: begin
                    if (in_from_unit.data_valid) begin
                        result_q[{lane_sel, 4'b0000} +: LANE_W] <= in_from_unit.data;
                        mask_q[lane_sel] <= 1'b0;
                        state_q          <= StIssSend;
`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
                    end else if (wd_q == WD_MAX) begin
                        // Unit went silent: poison the lane and move on.
                        result_q[{lane_sel, 4'b0000} +: LANE_W] <= BF16_QNAN;
                        mask_q[lane_sel] <= 1'b0;
                        timeout_q        <= 1'b1;
                        state_q          <= StIssSend;
                    end else begin
                        wd_q <= wd_q + 5'd1;
`endif
                    end
                end
                StIssDone: state_q <= StIssIdle;
                default:   state_q <= StIssIdle;
            endcase
        end
    end

    always_comb begin
        out_to_unit       = '0;
        out_to_unit.start = (state_q == StIssSend) && any_pending
                            && in_from_unit.can_accept_cmd;
        if (state_q != StIssIdle) begin
            out_to_unit.a = get_lane(a_q, lane_sel);
            out_to_unit.b = get_lane(b_q, lane_sel);
        end
    end

    assign out_can_accept = (state_q == StIssIdle);
    assign out_data_valid = valid_q;
    assign out_data       = result_q;
    assign out_dbg_state  = state_q;

endmodule

// File: tb/tb_snow64_bfloat16_binop_issuer.sv
// Directed + randomized bench for snow64_bfloat16_binop_issuer with a stub unit.
// Honours SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN for the silent-unit scenario.
module tb_snow64_bfloat16_binop_issuer;
  import snow64_bfloat16_binop_issuer_pkg::*;

  localparam int BOUND = 400;

  logic        clk;
  logic        rst;
  logic        in_start;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_lane_mask;
  logic        out_can_accept;
  logic        out_data_valid;
  logic [63:0] out_data;
  logic        out_timeout;
  PortIn_BinOp out_to_unit;
  PortOut_Oper from_unit;
  StateIssuer  dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int log_base = 0;
  int stub_lat = 3;
  int fn_mode = 0;
  int stall_until = 0;
  int force_dv_cyc = -1;
  bit mute = 0;
  int blocked_starts = 0;
  int start_log[$];

  bit          stub_busy = 0;
  int          stub_cnt = 0;
  logic [15:0] stub_res = '0;

  snow64_bfloat16_binop_issuer dut (
    .clk            (clk),
    .rst            (rst),
    .in_start       (in_start),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_lane_mask   (in_lane_mask),
    .out_can_accept (out_can_accept),
    .out_data_valid (out_data_valid),
    .out_data       (out_data),
    .out_timeout    (out_timeout),
    .out_to_unit    (out_to_unit),
    .in_from_unit   (from_unit),
    .out_dbg_state  (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  // Reference behaviour of the attached unit
  function automatic logic [15:0] unit_fn(input logic [15:0] a, input logic [15:0] b);
    if (fn_mode == 0) return 16'h4040;
    return a ^ {b[7:0], b[15:8]} ^ 16'h1357;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] m);
    logic [63:0] r;
    logic [15:0] la;
    logic [15:0] lb;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      la = a[n*16 +: 16];
      lb = b[n*16 +: 16];
      r[n*16 +: 16] = m[n] ? unit_fn(la, lb) : la;
    end
    return r;
  endfunction

  // Stub unit: answers L cycles after each accepted start.
  initial begin
    from_unit = '0;
    from_unit.can_accept_cmd = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      from_unit.data_valid = 1'b0;
      if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy = 0;
          if (!mute) begin
            from_unit.data_valid = 1'b1;
            from_unit.data = stub_res;
          end
        end else begin
          stub_cnt--;
        end
      end
      if (cyc == force_dv_cyc) begin
        from_unit.data_valid = 1'b1;
        from_unit.data = 16'hdead;
      end
      from_unit.can_accept_cmd = (cyc >= stall_until);
      #1;
      if (out_to_unit.start) begin
        if (!from_unit.can_accept_cmd) blocked_starts++;
        start_log.push_back(cyc);
        stub_busy = 1;
        stub_cnt = stub_lat;
        stub_res = unit_fn(out_to_unit.a, out_to_unit.b);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    in_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m,
                        input int lat, input bit glitch,
                        output logic [63:0] d, output int vc, output logic to);
    stub_lat = lat;
    log_base = start_log.size();
    in_a = a;
    in_b = b;
    in_lane_mask = m;
    in_start = 1'b1;
    t0 = cyc;
    vc = -1;
    d = 'x;
    to = 1'bx;
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      in_start = glitch && (i == 3);
      if (glitch && i == 3) begin
        in_a = ~a;
        in_b = ~b;
        in_lane_mask = 4'hf;
      end
      if (out_data_valid) begin
        vc = cyc - t0;
        d = out_data;
        to = out_timeout;
        @(negedge clk);
        break;
      end
    end
    in_start = 1'b0;
  endtask

  function automatic int rel_start(input int i);
    if (start_log.size() > log_base + i) return start_log[log_base + i] - t0;
    return -1;
  endfunction

  // main stimulus and scoreboard
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [3:0]  m;
    int          vc;
    int          lat;
    int          seen;
    int          ns;
    int          rs;
    logic        to;

    rst = 1'b1;
    in_start = 1'b0;
    in_a = '0;
    in_b = '0;
    in_lane_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    tests++;
    if (out_can_accept !== 1'b1) begin
      fails++;
      $error("FAIL reset_can_accept: got %0h", out_can_accept);
    end
    tests++;
    if (out_data !== 64'h0) begin
      fails++;
      $error("FAIL reset_data: got %0h", out_data);
    end
    tests++;
    if (out_data_valid !== 1'b0) begin
      fails++;
      $error("FAIL reset_valid: got %0h", out_data_valid);
    end
    tests++;
    if (out_timeout !== 1'b0) begin
      fails++;
      $error("FAIL reset_timeout: got %0h", out_timeout);
    end
    tests++;
    if (out_to_unit !== PortIn_BinOp'(0)) begin
      fails++;
      $error("FAIL reset_to_unit: got %0h", out_to_unit);
    end
    tests++;
    if (dbg_state !== StIssIdle) begin
      fails++;
      $error("FAIL reset_state: got %0h", dbg_state);
    end

    // Empty mask: passthrough, Done at cycle 2, idle at cycle 3
    fn_mode = 0;
    run_op(64'h1234_5678_9abc_def0, 64'hffff_ffff_ffff_ffff, 4'b0000, 3, 0, d, vc, to);
    tests++;
    if (d !== 64'h1234_5678_9abc_def0) begin
      fails++;
      $error("FAIL mask0_data: got %0h", d);
    end
    tests++;
    if (vc != 2) begin
      fails++;
      $error("FAIL mask0_valid_cycle: got %0d", vc);
    end
    ns = start_log.size() - log_base;
    tests++;
    if (ns != 0) begin
      fails++;
      $error("FAIL mask0_starts: got %0d", ns);
    end
    tests++;
    if (out_can_accept !== 1'b1) begin
      fails++;
      $error("FAIL mask0_can_accept_c3: got %0h", out_can_accept);
    end
    if (vc < 0) do_reset();

    // All lanes, L=3 constant-result adder
    run_op({4{16'h3f80}}, {4{16'h4000}}, 4'b1111, 3, 0, d, vc, to);
    tests++;
    if (d !== 64'h4040_4040_4040_4040) begin
      fails++;
      $error("FAIL all_data: got %0h", d);
    end
    tests++;
    if (vc != 18) begin
      fails++;
      $error("FAIL all_valid_cycle: got %0d", vc);
    end
    ns = start_log.size() - log_base;
    tests++;
    if (ns != 4) begin
      fails++;
      $error("FAIL all_starts: got %0d", ns);
    end
    for (int i = 0; i < 4; i++) begin
      rs = rel_start(i);
      tests++;
      if (rs != 1 + 4 * i) begin
        fails++;
        $error("FAIL all_start_cycle %0d: got %0d expected %0d", i, rs, 1 + 4 * i);
      end
    end
    tests++;
    if (out_to_unit !== PortIn_BinOp'(0)) begin
      fails++;
      $error("FAIL idle_to_unit_zero: got %0h", out_to_unit);
    end
    if (vc < 0) do_reset();

    // Randomized operations against the reference model
    fn_mode = 1;
    for (int it = 0; it < 6; it++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      m = 4'($urandom_range(0, 15));
      lat = $urandom_range(1, 4);
      exp_q.push_back(model(a, b, m));
      run_op(a, b, m, lat, 0, d, vc, to);
      exp_v = exp_q.pop_front();
      tests++;
      if (d !== exp_v) begin
        fails++;
        $error("FAIL rand_data: got %0h expected %0h", d, exp_v);
      end
      tests++;
      if (vc != 2 + $countones(m) * (lat + 1)) begin
        fails++;
        $error("FAIL rand_valid_cycle: got %0d", vc);
      end
      ns = start_log.size() - log_base;
      tests++;
      if (ns != $countones(m)) begin
        fails++;
        $error("FAIL rand_starts: got %0d", ns);
      end
      if (vc < 0) do_reset();
    end

    // Unit busy for 5 cycles, mask 0101
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    stall_until = cyc + 5;
    run_op(a, b, 4'b0101, 3, 0, d, vc, to);
    exp_v = model(a, b, 4'b0101);
    tests++;
    if (d !== exp_v) begin
      fails++;
      $error("FAIL stall_data: got %0h expected %0h", d, exp_v);
    end
    rs = rel_start(0);
    tests++;
    if (rs != 5) begin
      fails++;
      $error("FAIL stall_first_start: got %0d", rs);
    end
    tests++;
    if (vc != 14) begin
      fails++;
      $error("FAIL stall_valid_cycle: got %0d", vc);
    end
    if (vc < 0) do_reset();

    // Second in_start during Wait must be ignored
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_op(a, b, 4'b0110, 3, 1, d, vc, to);
    exp_v = model(a, b, 4'b0110);
    tests++;
    if (d !== exp_v) begin
      fails++;
      $error("FAIL glitch_data: got %0h expected %0h", d, exp_v);
    end
    tests++;
    if (vc != 10) begin
      fails++;
      $error("FAIL glitch_valid_cycle: got %0d", vc);
    end
    if (vc < 0) do_reset();

    // Reset while lane 2 is in flight
    fn_mode = 0;
    stub_lat = 3;
    log_base = start_log.size();
    in_a = {4{16'h1111}};
    in_b = {4{16'h2222}};
    in_lane_mask = 4'b1111;
    in_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    in_start = 1'b0;
    for (int i = 0; i < 100 && (start_log.size() - log_base) < 3; i++) @(negedge clk);
    ns = start_log.size() - log_base;
    tests++;
    if (ns != 3) begin
      fails++;
      $error("FAIL rst_lane2_started: got %0d", ns);
    end
    @(negedge clk);
    mute = 1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_can_accept !== 1'b1) begin
      fails++;
      $error("FAIL midrst_can_accept: got %0h", out_can_accept);
    end
    tests++;
    if (out_data !== 64'h0) begin
      fails++;
      $error("FAIL midrst_data: got %0h", out_data);
    end
    @(negedge clk);
    force_dv_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_data_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $error("FAIL stale_dv_no_valid: got %0d", seen);
    end
    tests++;
    if (out_can_accept !== 1'b1) begin
      fails++;
      $error("FAIL stale_dv_still_idle: got %0h", out_can_accept);
    end
    mute = 0;

    // After reset, issue still honours can_accept_cmd
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    stall_until = cyc + 4;
    run_op(a, b, 4'b0010, 2, 0, d, vc, to);
    exp_v = model(a, b, 4'b0010);
    tests++;
    if (d !== exp_v) begin
      fails++;
      $error("FAIL postrst_data: got %0h expected %0h", d, exp_v);
    end
    rs = rel_start(0);
    tests++;
    if (rs != 4) begin
      fails++;
      $error("FAIL postrst_first_start: got %0d", rs);
    end
    if (vc < 0) do_reset();

    // Silent unit on lane 0
    mute = 1;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
`ifdef SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN
    run_op(a, b, 4'b0001, 3, 0, d, vc, to);
    tests++;
    if (d !== {a[63:16], 16'h7fc0}) begin
      fails++;
      $error("FAIL wd_data: got %0h", d);
    end
    tests++;
    if (to !== 1'b1) begin
      fails++;
      $error("FAIL wd_timeout: got %0h", to);
    end
    tests++;
    if (vc != 35) begin
      fails++;
      $error("FAIL wd_valid_cycle: got %0d", vc);
    end
    if (vc < 0) do_reset();
    mute = 0;
    run_op(a, b, 4'b0000, 3, 0, d, vc, to);
    tests++;
    if (to !== 1'b0) begin
      fails++;
      $error("FAIL wd_cleared_on_accept: got %0h", to);
    end
`else
    in_a = a;
    in_b = b;
    in_lane_mask = 4'b0001;
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_data_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $error("FAIL nowd_no_valid: got %0d", seen);
    end
    tests++;
    if (out_can_accept !== 1'b0) begin
      fails++;
      $error("FAIL nowd_busy: got %0h", out_can_accept);
    end
    tests++;
    if (out_timeout !== 1'b0) begin
      fails++;
      $error("FAIL nowd_timeout: got %0h", out_timeout);
    end
    mute = 0;
    do_reset();
`endif

    tests++;
    if (blocked_starts != 0) begin
      fails++;
      $error("FAIL no_start_while_blocked: got %0d", blocked_starts);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snow64_bfloat16_binop_issuer.md
# snow64_bfloat16_binop_issuer

Command-side initiator for any BFloat16 binary-op unit (add, mul, div) that speaks the shared `PortIn_BinOp` / `PortOut_Oper` interface. It accepts a 64-bit vector operation of four packed BFloat16 lanes, issues the selected lanes one at a time to a single attached unit, collects each result, and returns the assembled 64-bit vector. It sits between the Snow64 vector execute stage and one scalar BFloat16 unit.

## Interface
Parameters:
- none (lane count fixed at 4, lane width 16)

Ports:
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_start` in 1: request strobe; sampled only when `out_can_accept`=1.
- `in_a`, `in_b` in 64 each: operands; lane n = bits [16n+15:16n].
- `in_lane_mask` in 4: bit n=1 means compute lane n; bit n=0 means lane n of `in_a` passes through.
- `out_can_accept` out 1: issuer is idle.
- `out_data_valid` out 1: one-cycle result strobe.
- `out_data` out 64: assembled result; held until the next accepted request.
- `out_timeout` out 1: valid with `out_data_valid`; tied 0 when the feature is compiled out.
- `out_to_unit` out `PortIn_BinOp`: `start`, `a`, `b` to the unit.
- `in_from_unit` in `PortOut_Oper`: `data_valid`, `can_accept_cmd`, `data` from the unit.

## Operation
- States: `StIssIdle`, `StIssSend`, `StIssWait`, `StIssDone`.
- Idle: `out_can_accept`=1. `in_start`=1 latches `in_a`, `in_b`, `in_lane_mask`, loads the result register with `in_a`, then goes to Send. `in_start` in any other state is ignored.
- Send: selects the lowest-index pending lane.
  - No lane pending: go to Done.
  - Lane pending and `can_accept_cmd`=1: drive `out_to_unit.start`=1 for this cycle only, with `a`/`b` set to that lane, then go to Wait.
  - Otherwise stay in Send with `start`=0.
- `out_to_unit.a`/`b` always show the currently selected lane, or 0 in Idle.
- Wait: on `data_valid`=1, write `data` into the selected lane of the result register, clear its mask bit, and return to Send. A `data_valid` seen in Idle, Send or Done is ignored.
- Done: `out_data_valid`=1 for one cycle, then Idle.
- Reset values: state Idle, `out_data`=0, `out_data_valid`=0, `out_timeout`=0, `out_to_unit`=0, pending mask 0.
- Reset mid-operation: the in-flight request is abandoned and no result strobe is produced. A late `data_valid` from the unit is ignored because the issuer is in Idle. Later issues still wait for `can_accept_cmd`.

## Timing
- `start` is combinational from state, pending mask and `can_accept_cmd`. All other outputs are registered.
- Request accepted at cycle 0. Send is at cycle 1.
- Mask 0: Done and `out_data_valid` at cycle 2; `out_can_accept` at cycle 3.
- Per-lane cost, with the unit always ready and latency L from `start` to `data_valid`: L+1 cycles.
- Total: `out_data_valid` at cycle 2 + k(L+1) for k active lanes.

## Configuration
- `SNOW64_BFLOAT16_ISSUER_TIMEOUT_EN` defined:
  - A 5-bit watchdog resets on entry to Wait and counts every Wait cycle.
  - At count 31 with no `data_valid`, the lane is written 16'h7fc0 (qNaN), its mask bit is cleared, a sticky timeout flag is set, and the issuer returns to Send.
  - `out_timeout` = sticky flag, cleared on accept.
- Undefined: no counter. Wait persists indefinitely; `out_timeout`=0.

## Structure
- Package additions: `StateIssuer` enum and `MSB_POS__SNOW64_BFLOAT16_ISSUER_STATE` define; `PortIn_Issuer`/`PortOut_Issuer` structs for the vector-side ports; lane-count and qNaN constants.
- Sub-module: `snow64_bfloat16_lane_picker`, a combinational priority encoder from pending mask to lane index plus an any-pending flag.

## Test plan
- Mask 4'b0000, `in_a`=64'h1234_5678_9abc_def0 -> `out_data`=64'h1234_5678_9abc_def0, `out_data_valid` at cycle 2, no `start` pulses.
- Mask 4'b1111, all lanes a=16'h3f80, b=16'h4000, stub adder L=3 returning 16'h4040 -> exactly 4 `start` pulses (cycles 1, 5, 9, 13), `out_data`=64'h4040_4040_4040_4040 at cycle 18.
- Mask 4'b0101, stub `can_accept_cmd` low for 5 cycles -> no `start` while low; lanes 1 and 3 equal `in_a`; lanes 0 and 2 equal the stub results.
- `in_start` pulsed while in Wait with different operands -> ignored; result matches the first request only.
- `rst` asserted during lane 2 Wait -> `out_can_accept`=1 and `out_data`=0 the next cycle; a stale `data_valid` two cycles later produces no `out_data_valid`.
- Stub never asserts `data_valid`, mask 4'b0001: with the macro, `out_data` lane 0 = 16'h7fc0 and `out_timeout`=1 with `out_data_valid`; without the macro, the issuer remains in Wait for 100 cycles.
